// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b memory access path.
package lc3b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE,
    ST_FAULT
  } mau_state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Access size as carried on the 'word' control bit.
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Byte-lane enables on mem_be.
  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side handshake between the access unit (master) and memory (slave).
interface mem_access_unit_if;

  logic        mem_cs;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_cs, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_cs, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: lane enables, store-data replication and
// sign-extended byte load data.
module mem_lane_fmt
  import lc3b_pkg::*;
(
  input  logic        word,
  input  logic        addr0,
  input  logic [15:0] wdata,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  be,
  output logic [15:0] wdata_fmt,
  output logic [15:0] rdata_fmt
);

  logic [7:0] lane;

  // Select lane enables and align data for word or byte accesses.
  always_comb begin
    be        = BE_NONE;
    wdata_fmt = '0;
    rdata_fmt = '0;
    lane      = '0;
    case (word)
      SIZE_WORD: begin
        be        = BE_WORD;
        wdata_fmt = wdata;
        rdata_fmt = mem_rdata;
      end
      SIZE_BYTE: begin
        be        = addr0 ? BE_HI : BE_LO;
        wdata_fmt = {wdata[7:0], wdata[7:0]};
        lane      = addr0 ? mem_rdata[15:8] : mem_rdata[7:0];
        rdata_fmt = {{8{lane[7]}}, lane};
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the LC-3b control path and a ready-handshake
// memory. Handles byte lanes, misaligned-word faults and a ready timeout.
module mem_access_unit
  import lc3b_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               we,
  input  logic               word,
  input  logic [15:0]        addr,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  mem_access_unit_if.master  mem
);

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  mau_state_t  state;
  logic [7:0]  tcnt;
  logic        lat_we;
  logic        lat_word;
  logic        lat_a0;

  logic        fmt_word;
  logic        fmt_a0;
  logic [1:0]  fmt_be;
  logic [15:0] fmt_wdata;
  logic [15:0] fmt_rdata;

  // The single formatter serves both request decode (IDLE, live inputs) and
  // load capture (ISSUE, latched size/lane), so its select inputs are muxed.
  always_comb begin
    fmt_word = lat_word;
    fmt_a0   = lat_a0;
    if (state == ST_IDLE) begin
      fmt_word = word;
      fmt_a0   = addr[0];
    end
  end

  mem_lane_fmt u_fmt (
    .word      (fmt_word),
    .addr0     (fmt_a0),
    .wdata     (wdata),
    .mem_rdata (mem.mem_rdata),
    .be        (fmt_be),
    .wdata_fmt (fmt_wdata),
    .rdata_fmt (fmt_rdata)
  );

  // Access FSM with registered status and memory-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      tcnt          <= '0;
      lat_we        <= 1'b0;
      lat_word      <= 1'b0;
      lat_a0        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      mem.mem_cs    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= BE_NONE;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_we   <= we;
            lat_word <= word;
            lat_a0   <= addr[0];
            busy     <= 1'b1;
            if (word && addr[0]) begin
              state <= ST_FAULT;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state         <= ST_ISSUE;
              tcnt          <= '0;
              mem.mem_cs    <= 1'b1;
              mem.mem_we    <= we;
              mem.mem_be    <= fmt_be;
              mem.mem_addr  <= {addr[15:1], 1'b0};
              mem.mem_wdata <= fmt_wdata;
            end
          end
        end
        ST_ISSUE: begin
          if (mem.mem_ready) begin
            state      <= ST_DONE;
            done       <= 1'b1;
            mem.mem_cs <= 1'b0;
            mem.mem_we <= 1'b0;
            mem.mem_be <= BE_NONE;
            if (!lat_we) begin
              rdata <= fmt_rdata;
            end
          end else if (tcnt == TCNT_LAST) begin
            state      <= ST_FAULT;
            done       <= 1'b1;
            err        <= 1'b1;
            mem.mem_cs <= 1'b0;
            mem.mem_we <= 1'b0;
            mem.mem_be <= BE_NONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        ST_DONE, ST_FAULT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, random aligned
// loads, and a reset-during-access sequence, checked through a scoreboard.
module tb_mem_access_unit;

  localparam int unsigned TMO = 4;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic        word;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  mem_access_unit_if mif ();

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .word  (word),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .mem   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrdata;
    int unsigned rdly;     // ISSUE cycles with mem_ready low; 255 = never ready
    logic        fault;
    logic [1:0]  be;
    logic [15:0] maddr;
    logic [15:0] mwdata;
    logic [15:0] rdata;    // rdata expected at done (held value if no load)
    int unsigned lat;      // falling edges from req to done
    int unsigned cs_n;     // cycles with mem_cs high
  } vec_t;

  vec_t        sb[$];
  vec_t        vt[11];
  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned cyc;
  logic        saw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ld_model(input logic wd, input logic a0, input logic [15:0] d);
    logic [7:0] b;
    if (wd) return d;
    b = a0 ? d[15:8] : d[7:0];
    return {{8{b[7]}}, b};
  endfunction

  task automatic run_access(input vec_t v, input string tag);
    vec_t        e;
    int unsigned n;
    int unsigned cs_cyc;
    logic        got;
    logic        side_ok;
    logic [1:0]  be_s;
    logic [15:0] addr_s;
    logic [15:0] wd_s;
    logic        we_s;
    sb.push_back(v);
    req = 1'b1; we = v.we; word = v.word; addr = v.addr; wdata = v.wdata;
    mif.mem_rdata = v.mrdata;
    n = 0; cs_cyc = 0; got = 1'b0; side_ok = 1'b1;
    be_s = '0; addr_s = '0; wd_s = '0; we_s = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (mif.mem_cs) begin
        cs_cyc++;
        be_s = mif.mem_be; addr_s = mif.mem_addr; wd_s = mif.mem_wdata; we_s = mif.mem_we;
        mif.mem_ready = (cs_cyc > v.rdly);
      end else begin
        if (mif.mem_be != 2'b00 || mif.mem_we != 1'b0) side_ok = 1'b0;
        mif.mem_ready = 1'b1;
      end
      if (done) got = 1'b1;
    end
    req = 1'b0;
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 32'(got), 32'(1));
    if (got) begin
      chk({tag, "_err"}, 32'(err), 32'(e.fault));
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_cs_cycles"}, cs_cyc, e.cs_n);
      chk({tag, "_rdata"}, 32'(rdata), 32'(e.rdata));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'(1));
      chk({tag, "_idle_strobes"}, 32'(side_ok), 32'(1));
      if (e.cs_n != 0) begin
        chk({tag, "_mem_be"}, 32'(be_s), 32'(e.be));
        chk({tag, "_mem_addr"}, 32'(addr_s), 32'(e.maddr));
        chk({tag, "_mem_we"}, 32'(we_s), 32'(e.we));
        chk({tag, "_mem_wdata"}, 32'(wd_s), 32'(e.mwdata));
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'(0));
      chk({tag, "_busy_after"}, 32'(busy), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b0; req = 1'b0; we = 1'b0; word = 1'b0; addr = '0; wdata = '0;
    mif.mem_rdata = '0; mif.mem_ready = 1'b1;

    //          we    word  addr      wdata     mrdata    rdly flt   be     maddr     mwdata    rdata    lat cs
    vt[0]  = '{1'b0, 1'b1, 16'h3000, 16'h1234, 16'hBEEF, 0,   1'b0, 2'b11, 16'h3000, 16'h1234, 16'hBEEF, 2, 1};
    vt[1]  = '{1'b0, 1'b0, 16'h3001, 16'h0000, 16'h8012, 0,   1'b0, 2'b10, 16'h3000, 16'h0000, 16'hFF80, 2, 1};
    vt[2]  = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h8012, 0,   1'b0, 2'b01, 16'h3000, 16'h0000, 16'h0012, 2, 1};
    vt[3]  = '{1'b1, 1'b0, 16'h4001, 16'h00A5, 16'hFFFF, 2,   1'b0, 2'b10, 16'h4000, 16'hA5A5, 16'h0012, 4, 3};
    vt[4]  = '{1'b1, 1'b1, 16'h4003, 16'h1111, 16'hFFFF, 0,   1'b1, 2'b00, 16'h0000, 16'h0000, 16'h0012, 1, 0};
    vt[5]  = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'h7777, 255, 1'b1, 2'b11, 16'h3000, 16'h0000, 16'h0012, 5, 4};
    vt[6]  = '{1'b0, 1'b0, 16'h2002, 16'h0000, 16'h017F, 1,   1'b0, 2'b01, 16'h2002, 16'h0000, 16'h007F, 3, 2};
    vt[7]  = '{1'b1, 1'b1, 16'h5554, 16'hCAFE, 16'h0000, 0,   1'b0, 2'b11, 16'h5554, 16'hCAFE, 16'h007F, 2, 1};
    vt[8]  = '{1'b0, 1'b0, 16'h1235, 16'h0000, 16'h9C55, 0,   1'b0, 2'b10, 16'h1234, 16'h0000, 16'hFF9C, 2, 1};
    vt[9]  = '{1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0000, 0,   1'b1, 2'b00, 16'h0000, 16'h0000, 16'hFF9C, 1, 0};
    vt[10] = '{1'b1, 1'b0, 16'h0010, 16'h12C3, 16'h0000, 0,   1'b0, 2'b01, 16'h0010, 16'hC3C3, 16'hFF9C, 2, 1};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_mem_cs", 32'(mif.mem_cs), 32'(0));
    chk("rst_mem_we", 32'(mif.mem_we), 32'(0));
    chk("rst_mem_be", 32'(mif.mem_be), 32'(0));
    chk("rst_mem_addr", 32'(mif.mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mif.mem_wdata), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_access(vt[i], $sformatf("v%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.we     = 1'b0;
      v.word   = 1'($urandom_range(0, 1));
      v.addr   = 16'($urandom);
      if (v.word) v.addr[0] = 1'b0;
      v.wdata  = 16'($urandom);
      v.mrdata = 16'($urandom);
      v.rdly   = $urandom_range(0, 2);
      v.fault  = 1'b0;
      v.be     = v.word ? 2'b11 : (v.addr[0] ? 2'b10 : 2'b01);
      v.maddr  = {v.addr[15:1], 1'b0};
      v.mwdata = v.word ? v.wdata : {v.wdata[7:0], v.wdata[7:0]};
      v.rdata  = ld_model(v.word, v.addr[0], v.mrdata);
      v.lat    = 2 + v.rdly;
      v.cs_n   = 1 + v.rdly;
      run_access(v, $sformatf("r%0d", i));
    end

    // Reset pulse while ISSUE waits on a slow memory.
    mif.mem_ready = 1'b0;
    req = 1'b1; we = 1'b0; word = 1'b1; addr = 16'h0200; wdata = '0;
    mif.mem_rdata = 16'h1111;
    cyc = 0;
    while (!mif.mem_cs && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_issue_reached", 32'(mif.mem_cs), 32'(1));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_cs_async", 32'(mif.mem_cs), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_be", 32'(mif.mem_be), 32'(0));
    chk("rst_mid_addr", 32'(mif.mem_addr), 32'(0));
    req = 1'b0;
    saw = done;
    repeat (2) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("rst_mid_no_done", 32'(saw), 32'(0));
    chk("rst_mid_rdata_cleared", 32'(rdata), 32'(0));

    begin
      vec_t v;
      v = '{1'b0, 1'b1, 16'h0100, 16'h0000, 16'h5A5A, 0, 1'b0, 2'b11, 16'h0100, 16'h0000, 16'h5A5A, 2, 1};
      run_access(v, "post_rst");
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ISSUE-state cycles spent waiting for mem_ready (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all flops update on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 1, access request from the control path, sampled only in IDLE.
REQ-005 SHALL have port we, input, 1, meaning 1 = store and 0 = load.
REQ-006 SHALL have port word, input, 1, meaning 1 = LDW/STW and 0 = LDB/STB.
REQ-007 SHALL have port addr, input, 16, the byte address from MAR.
REQ-008 SHALL have port wdata, input, 16, the store data from MDR.
REQ-009 SHALL have port rdata, output, 16, the formatted load result, valid while done=1 and held until the next load completes.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1, error status, valid with done.
REQ-013 SHALL have ports mem_cs (out, 1), mem_we (out, 1), mem_be (out, 2), mem_addr (out, 16), mem_wdata (out, 16), mem_rdata (in, 16) and mem_ready (in, 1) forming the memory-side handshake.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, DONE and FAULT.
REQ-015 SHALL, in IDLE with req=1, latch we, word, addr and wdata, then go to FAULT if word=1 and addr[0]=1, else to ISSUE.
REQ-016 SHALL ignore req in every state other than IDLE; requests are neither queued nor dropped silently, because the controller holds req until done.
REQ-017 SHALL, in ISSUE, drive mem_cs=1, mem_we=latched we, and mem_addr={addr[15:1],1'b0}, all stable until exit.
REQ-018 SHALL drive mem_be: word gives 2'b11; byte with addr[0]=0 gives 2'b01; byte with addr[0]=1 gives 2'b10.
REQ-019 SHALL drive mem_wdata: word gives wdata; byte gives {wdata[7:0],wdata[7:0]}.
REQ-020 SHALL, when mem_ready=1 is sampled in ISSUE, capture formatted mem_rdata (loads only) and go to DONE.
REQ-021 SHALL format loads as follows: word gives mem_rdata; byte gives the selected lane (addr[0]=1 selects the high lane) sign-extended to 16 bits.
REQ-022 SHALL count ISSUE cycles and, when TIMEOUT cycles elapse without mem_ready, go to FAULT; the counter clears on every ISSUE entry.
REQ-023 SHALL, in DONE, assert done=1 and err=0 for exactly one cycle, then go to IDLE.
REQ-024 SHALL, in FAULT, assert done=1 and err=1 for one cycle with no memory access and rdata unchanged, then go to IDLE.
REQ-025 SHALL meet these latencies: req at edge N with mem_ready tied high gives done high after edge N+2; a misaligned request gives done after edge N+1.
REQ-026 SHALL drive mem_cs, mem_we and mem_be to 0 in every state except ISSUE.
REQ-027 SHALL treat mem_ready outside ISSUE as don't-care.

Reset
REQ-028 SHALL, while reset=0, immediately force state=IDLE, busy=0, done=0, err=0, rdata=0, mem_cs=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0 and timeout count=0.
REQ-029 SHALL, on reset asserted mid-access, abort the access with no done pulse, and SHALL ignore the first req only if it coincides with the deassertion edge.

Structure
REQ-030 SHALL place the FSM state enum, the TIMEOUT default, and the access-size and byte-lane constants in a shared package lc3b_pkg.
REQ-031 SHALL use one combinational sub-module, mem_lane_fmt, that computes mem_be, replicated wdata and the sign-extended byte rdata from word, addr[0] and the data.

Verification
REQ-032 SHALL cover: LDW at addr 0x3000 with mem_rdata=0xBEEF and ready tied high -> mem_be=11, rdata=0xBEEF, done after edge N+2, err=0.
REQ-033 SHALL cover: LDB at addr 0x3001 with mem_rdata=0x8012 -> mem_addr=0x3000, rdata=0xFF80; and LDB at 0x3000 -> rdata=0x0012.
REQ-034 SHALL cover: STB at addr 0x4001 with wdata=0x00A5 -> mem_we=1, mem_be=10, mem_wdata=0xA5A5, done one cycle after ready.
REQ-035 SHALL cover: STW at addr 0x4003 -> no mem_cs pulse, done=1 and err=1 one cycle after req.
REQ-036 SHALL cover: LDW with mem_ready held low and TIMEOUT=4 -> mem_cs high for exactly 4 cycles, then done=1 and err=1.
REQ-037 SHALL cover: reset=0 pulsed during ISSUE with ready delayed -> mem_cs drops asynchronously, no done, and the next req completes normally.
